// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the datapath control sequencer:
//   - opcode constants carried in instr[31:29]
//   - sequencer state encoding
//   - instruction field bit positions and the decoded-field struct
//   - FS_PASS, the ALU pass-A function used to route a register to RAM
//   - is_legal_op(), the opcode legality check
// ---------------------------------------------------------------------------
package ctrl_pkg;

    // Opcodes
    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOADI = 3'b001;
    localparam logic [2:0] OP_ALU   = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_LOADM = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // ALU pass-A function: a STORE pushes srcA through the ALU unchanged
    localparam logic [4:0] FS_PASS = 5'b01000;

    // Instruction field bit positions
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 29;
    localparam int FS_MSB   = 28;
    localparam int FS_LSB   = 24;
    localparam int DEST_MSB = 23;
    localparam int DEST_LSB = 19;
    localparam int SRCA_MSB = 18;
    localparam int SRCA_LSB = 14;
    localparam int SRCB_MSB = 13;
    localparam int SRCB_LSB = 9;
    localparam int CIN_BIT  = 8;
    localparam int IMM_MSB  = 13;
    localparam int IMM_LSB  = 0;
    localparam int IMM_W    = IMM_MSB - IMM_LSB + 1;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        ST     = 3'd4,
        HALT   = 3'd5
    } ctrl_state_e;

    // Fields pulled out of one instruction word (widths fixed by the format)
    typedef struct packed {
        logic [2:0] op;
        logic [4:0] fs;
        logic [4:0] dest;
        logic [4:0] src_a;
        logic [4:0] src_b;
        logic       cin;
    } instr_fields_t;

    // 101 and 110 are the only unassigned opcodes
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_NOP, OP_LOADI, OP_ALU, OP_STORE, OP_LOADM, OP_HALT: legal = 1'b1;
            default:                                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/datapath_ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational instruction decoder.
// Ports:
//   word      in  32       instruction word to decode
//   fields    out struct   op / FS / dest / srcA / srcB / Cin
//   imm_sext  out DATA_W   imm[13:0] sign-extended to the data bus width
//   illegal   out 1        opcode is 101 or 110
// ---------------------------------------------------------------------------
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       word,
    output instr_fields_t     fields,
    output logic [DATA_W-1:0] imm_sext,
    output logic              illegal
);

    // Field extraction, immediate sign extension and legality check
    always_comb begin
        fields.op    = word[OP_MSB:OP_LSB];
        fields.fs    = word[FS_MSB:FS_LSB];
        fields.dest  = word[DEST_MSB:DEST_LSB];
        fields.src_a = word[SRCA_MSB:SRCA_LSB];
        fields.src_b = word[SRCB_MSB:SRCB_LSB];
        fields.cin   = word[CIN_BIT];
        imm_sext     = {{(DATA_W-IMM_W){word[IMM_MSB]}}, word[IMM_MSB:IMM_LSB]};
        illegal      = ~is_legal_op(word[OP_MSB:OP_LSB]);
    end

endmodule

// File: rtl/datapath_ctrl.sv
// ---------------------------------------------------------------------------
// datapath_ctrl
// Control sequencer feeding the register file / ALU / RAM datapath. Accepts
// instruction words over a valid/ready handshake, decodes them and drives a
// fully registered (Moore) control word. ALU and STORE ops wait on the ALU
// `stat` completion handshake before writeback or store.
//
// Optional build macro: CTRL_ALU_TIMEOUT_EN
//   defined   -> EXEC watchdog of ALU_WAIT_MAX cycles, alu_timeout port
//   undefined -> EXEC waits forever, no counter, no alu_timeout port
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_valid/instr_ready    instruction handshake, instr = word
//   stat, Cout                 ALU done strobe and carry out
//   Cin, RegWrite, RAMWrite    ALU carry in, register / RAM write strobes
//   MUXSelect, InSelect        register input routing (RAMout / ALU_Out)
//   ALUstart, FS               ALU request and function select
//   data                       immediate for the register input
//   wrAddr, rdAddrA, rdAddrB   register-file addresses
//   busy, halted               status
//   carry_flag                 Cout of the last completed ALU op
//   illegal_op, alu_timeout    sticky error flags
// ---------------------------------------------------------------------------
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int FS_W   = 5
`ifdef CTRL_ALU_TIMEOUT_EN
    , parameter int ALU_WAIT_MAX = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              stat,
    input  logic              Cout,
    output logic              Cin,
    output logic              RegWrite,
    output logic              RAMWrite,
    output logic              MUXSelect,
    output logic              InSelect,
    output logic              ALUstart,
    output logic [DATA_W-1:0] data,
    output logic [FS_W-1:0]   FS,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [ADDR_W-1:0] rdAddrA,
    output logic [ADDR_W-1:0] rdAddrB,
    output logic              busy,
    output logic              halted,
    output logic              carry_flag,
    output logic              illegal_op
`ifdef CTRL_ALU_TIMEOUT_EN
    , output logic            alu_timeout
`endif
);

    ctrl_state_e       state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic              exec_first_q, exec_first_d;

    logic              instr_ready_q, instr_ready_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              reg_write_q, reg_write_d;
    logic              ram_write_q, ram_write_d;
    logic              alu_start_q, alu_start_d;
    logic              mux_select_q, mux_select_d;
    logic              in_select_q, in_select_d;
    logic              cin_q, cin_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [FS_W-1:0]   fs_q, fs_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
    logic              carry_flag_q, carry_flag_d;
    logic              illegal_op_q, illegal_op_d;

    logic [31:0]       dec_word_s;
    instr_fields_t     dec_f_s;
    logic [DATA_W-1:0] dec_imm_s;
    logic              dec_illegal_s;
    logic              exec_done_s;

`ifdef CTRL_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(ALU_WAIT_MAX + 1);
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              alu_timeout_q, alu_timeout_d;
    logic              exec_expired_s;
`endif

    // While waiting for a word the decoder looks at the live bus so the
    // address/FS/Cin registers load on the accept edge; afterwards it looks
    // at the latched IR.
    always_comb begin
        if (state_q == IDLE) begin
            dec_word_s = instr;
        end else begin
            dec_word_s = ir_q;
        end
        // The first EXEC cycle may see a stale done from the previous op
        exec_done_s = (state_q == EXEC) && !exec_first_q && stat;
    end

    ctrl_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .word     (dec_word_s),
        .fields   (dec_f_s),
        .imm_sext (dec_imm_s),
        .illegal  (dec_illegal_s)
    );

`ifdef CTRL_ALU_TIMEOUT_EN
    // EXEC-cycle counter for the ALU watchdog
    always_comb begin
        if (state_q == EXEC) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = {CNT_W{1'b0}};
        end
        exec_expired_s = (state_q == EXEC) && (wait_cnt_q == CNT_W'(ALU_WAIT_MAX - 1));
    end
`endif

    // Next-state, register loads and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        rd_addr_a_d  = rd_addr_a_q;
        rd_addr_b_d  = rd_addr_b_q;
        wr_addr_d    = wr_addr_q;
        fs_d         = fs_q;
        cin_d        = cin_q;
        data_d       = data_q;
        carry_flag_d = carry_flag_q;
        illegal_op_d = illegal_op_q;
`ifdef CTRL_ALU_TIMEOUT_EN
        alu_timeout_d = alu_timeout_q;
`endif

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d     = DECODE;
                    ir_d        = instr;
                    rd_addr_a_d = ADDR_W'(dec_f_s.src_a);
                    rd_addr_b_d = ADDR_W'(dec_f_s.src_b);
                    wr_addr_d   = ADDR_W'(dec_f_s.dest);
                    fs_d        = FS_W'(dec_f_s.fs);
                    cin_d       = dec_f_s.cin;
                end else begin
                    state_d = IDLE;
                end
            end
            DECODE: begin
                if (dec_illegal_s) begin
                    illegal_op_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    case (dec_f_s.op)
                        OP_NOP:   state_d = IDLE;
                        OP_LOADI: begin
                            state_d = WB;
                            data_d  = dec_imm_s;
                        end
                        OP_LOADM: state_d = WB;
                        OP_ALU:   state_d = EXEC;
                        OP_STORE: begin
                            state_d = EXEC;
                            fs_d    = FS_W'(FS_PASS);
                        end
                        OP_HALT:  state_d = HALT;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            EXEC: begin
                if (exec_done_s) begin
                    carry_flag_d = Cout;
                    state_d      = (dec_f_s.op == OP_STORE) ? ST : WB;
`ifdef CTRL_ALU_TIMEOUT_EN
                end else if (exec_expired_s) begin
                    alu_timeout_d = 1'b1;
                    state_d       = IDLE;
`endif
                end else begin
                    state_d = EXEC;
                end
            end
            WB:      state_d = IDLE;
            ST:      state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // Moore outputs: registered alongside the state they belong to
        instr_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE) && (state_d != HALT);
        halted_d      = (state_d == HALT);
        alu_start_d   = (state_d == EXEC);
        reg_write_d   = (state_d == WB);
        ram_write_d   = (state_d == ST);
        // ALU result path stays selected from EXEC until the op retires
        in_select_d   = (state_d == EXEC) || (state_d == ST)
                        || ((state_d == WB) && (dec_f_s.op == OP_ALU));
        mux_select_d  = (state_d == WB) && (dec_f_s.op == OP_LOADM);
        exec_first_d  = (state_q != EXEC);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ir_q          <= 32'd0;
            exec_first_q  <= 1'b1;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            reg_write_q   <= 1'b0;
            ram_write_q   <= 1'b0;
            alu_start_q   <= 1'b0;
            mux_select_q  <= 1'b0;
            in_select_q   <= 1'b0;
            cin_q         <= 1'b0;
            data_q        <= {DATA_W{1'b0}};
            fs_q          <= {FS_W{1'b0}};
            wr_addr_q     <= {ADDR_W{1'b0}};
            rd_addr_a_q   <= {ADDR_W{1'b0}};
            rd_addr_b_q   <= {ADDR_W{1'b0}};
            carry_flag_q  <= 1'b0;
            illegal_op_q  <= 1'b0;
`ifdef CTRL_ALU_TIMEOUT_EN
            wait_cnt_q    <= {CNT_W{1'b0}};
            alu_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            exec_first_q  <= exec_first_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            reg_write_q   <= reg_write_d;
            ram_write_q   <= ram_write_d;
            alu_start_q   <= alu_start_d;
            mux_select_q  <= mux_select_d;
            in_select_q   <= in_select_d;
            cin_q         <= cin_d;
            data_q        <= data_d;
            fs_q          <= fs_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_a_q   <= rd_addr_a_d;
            rd_addr_b_q   <= rd_addr_b_d;
            carry_flag_q  <= carry_flag_d;
            illegal_op_q  <= illegal_op_d;
`ifdef CTRL_ALU_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            alu_timeout_q <= alu_timeout_d;
`endif
        end
    end

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign RegWrite    = reg_write_q;
    assign RAMWrite    = ram_write_q;
    assign ALUstart    = alu_start_q;
    assign MUXSelect   = mux_select_q;
    assign InSelect    = in_select_q;
    assign Cin         = cin_q;
    assign data        = data_q;
    assign FS          = fs_q;
    assign wrAddr      = wr_addr_q;
    assign rdAddrA     = rd_addr_a_q;
    assign rdAddrB     = rd_addr_b_q;
    assign carry_flag  = carry_flag_q;
    assign illegal_op  = illegal_op_q;
`ifdef CTRL_ALU_TIMEOUT_EN
    assign alu_timeout = alu_timeout_q;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// ---------------------------------------------------------------------------
// tb_datapath_ctrl
// Directed bench for datapath_ctrl. A transaction-level model tracks each
// accepted instruction by its age in clock edges since the accept edge and
// derives the expected control word from that; every negative edge the DUT
// outputs are compared with it. Literal checks at key cycles pin the model.
// ---------------------------------------------------------------------------
module tb_datapath_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        stat;
    logic        Cout;
    logic        Cin;
    logic        RegWrite;
    logic        RAMWrite;
    logic        MUXSelect;
    logic        InSelect;
    logic        ALUstart;
    logic [63:0] data;
    logic [4:0]  FS;
    logic [4:0]  wrAddr;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic        busy;
    logic        halted;
    logic        carry_flag;
    logic        illegal_op;
`ifdef CTRL_ALU_TIMEOUT_EN
    logic        alu_timeout;
`endif

    datapath_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .stat        (stat),
        .Cout        (Cout),
        .Cin         (Cin),
        .RegWrite    (RegWrite),
        .RAMWrite    (RAMWrite),
        .MUXSelect   (MUXSelect),
        .InSelect    (InSelect),
        .ALUstart    (ALUstart),
        .data        (data),
        .FS          (FS),
        .wrAddr      (wrAddr),
        .rdAddrA     (rdAddrA),
        .rdAddrB     (rdAddrB),
        .busy        (busy),
        .halted      (halted),
        .carry_flag  (carry_flag),
        .illegal_op  (illegal_op)
`ifdef CTRL_ALU_TIMEOUT_EN
        , .alu_timeout (alu_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;
    int rw_cnt  = 0;
    int alu_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic        m_act, m_done;
    int          m_age;
    logic [31:0] m_word;
    logic        m_rdy, m_busy, m_hlt, m_rw, m_ramw, m_alu, m_mux, m_insel, m_cin;
    logic        m_carry, m_ill, m_to;
    logic [4:0]  m_fs, m_wa, m_ra, m_rb;
    logic [63:0] m_data;

    task automatic model_finish();
        m_act  <= 1'b0;
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
        m_rw   <= 1'b0;
        m_ramw <= 1'b0;
        m_alu  <= 1'b0;
        m_mux  <= 1'b0;
        m_insel <= 1'b0;
    endtask

    always @(posedge clk) begin : model_p
        logic [2:0] op;
        int nage;
        op   = m_word[31:29];
        nage = m_age + 1;
        if (reset) begin
            m_act <= 1'b0; m_done <= 1'b0; m_age <= 0; m_word <= 32'd0;
            m_rdy <= 1'b1; m_busy <= 1'b0; m_hlt <= 1'b0; m_rw <= 1'b0;
            m_ramw <= 1'b0; m_alu <= 1'b0; m_mux <= 1'b0; m_insel <= 1'b0;
            m_cin <= 1'b0; m_fs <= 5'd0; m_wa <= 5'd0; m_ra <= 5'd0; m_rb <= 5'd0;
            m_data <= 64'd0; m_carry <= 1'b0; m_ill <= 1'b0; m_to <= 1'b0;
        end else if (m_hlt) begin
            m_rdy <= 1'b0;
        end else if (!m_act) begin
            if (instr_valid) begin
                m_act <= 1'b1; m_done <= 1'b0; m_age <= 0; m_word <= instr;
                m_rdy <= 1'b0; m_busy <= 1'b1;
                m_ra <= instr[18:14]; m_rb <= instr[13:9]; m_wa <= instr[23:19];
                m_fs <= instr[28:24]; m_cin <= instr[8];
            end
        end else begin
            m_age <= nage;
            case (op)
                3'b000: model_finish();
                3'b001, 3'b100: begin
                    if (nage == 1) begin
                        m_rw <= 1'b1;
                        if (op == 3'b001) m_data <= {{50{m_word[13]}}, m_word[13:0]};
                        else m_mux <= 1'b1;
                    end else begin
                        model_finish();
                    end
                end
                3'b010, 3'b011: begin
                    if (nage == 1) begin
                        m_alu <= 1'b1; m_insel <= 1'b1;
                        if (op == 3'b011) m_fs <= 5'b01000;
                    end else if (m_done) begin
                        model_finish();
                    end else if (nage >= 3 && stat) begin
                        m_done <= 1'b1; m_carry <= Cout; m_alu <= 1'b0;
                        if (op == 3'b010) m_rw <= 1'b1;
                        else m_ramw <= 1'b1;
`ifdef CTRL_ALU_TIMEOUT_EN
                    end else if (nage == 16) begin
                        m_to <= 1'b1;
                        model_finish();
`endif
                    end
                end
                3'b111: begin
                    m_hlt <= 1'b1; m_busy <= 1'b0; m_act <= 1'b0;
                end
                default: begin
                    m_ill <= 1'b1;
                    model_finish();
                end
            endcase
        end
    end

    // Strobe activity counters (pre-edge values)
    always @(posedge clk) begin
        if (RegWrite === 1'b1) rw_cnt <= rw_cnt + 1;
        if (ALUstart === 1'b1) alu_cnt <= alu_cnt + 1;
    end

    // Compare DUT against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", instr_ready, m_rdy);
            check("busy", busy, m_busy);
            check("halted", halted, m_hlt);
            check("RegWrite", RegWrite, m_rw);
            check("RAMWrite", RAMWrite, m_ramw);
            check("ALUstart", ALUstart, m_alu);
            check("MUXSelect", MUXSelect, m_mux);
            check("InSelect", InSelect, m_insel);
            check("Cin", Cin, m_cin);
            check("FS", FS, m_fs);
            check("wrAddr", wrAddr, m_wa);
            check("rdAddrA", rdAddrA, m_ra);
            check("rdAddrB", rdAddrB, m_rb);
            check("data", data, m_data);
            check("carry_flag", carry_flag, m_carry);
            check("illegal_op", illegal_op, m_ill);
`ifdef CTRL_ALU_TIMEOUT_EN
            check("alu_timeout", alu_timeout, m_to);
`endif
        end
    end

    // Present a word at a negedge once ready; returns at the negedge after accept
    task automatic send(input logic [31:0] w);
        int k;
        k = 0;
        while (instr_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("send_ready_timeout", {63'd0, instr_ready}, 64'd1);
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int rw_base;
    int alu_base;

    initial begin : stim
        reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; stat = 1'b0; Cout = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", {63'd0, instr_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_data", data, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // NOP: back in IDLE one edge after DECODE
        send(32'd0);
        check("nop_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("nop_ready", {63'd0, instr_ready}, 64'd1);

        // LOADI dest=3 imm=3FFF
        rw_base = rw_cnt;
        send({3'b001, 5'd0, 5'd3, 5'd0, 14'h3FFF});
        @(negedge clk);
        check("loadi_rw", {63'd0, RegWrite}, 64'd1);
        check("loadi_data", data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("loadi_insel", {63'd0, InSelect}, 64'd0);
        check("loadi_wr", {59'd0, wrAddr}, 64'd3);
        @(negedge clk);
        check("loadi_rw_off", {63'd0, RegWrite}, 64'd0);
        check("loadi_ready", {63'd0, instr_ready}, 64'd1);
        check("loadi_pulses", 64'(rw_cnt - rw_base), 64'd1);

        // LOADM dest=7
        send({3'b100, 5'd0, 5'd7, 5'd2, 5'd0, 1'b0, 8'd0});
        @(negedge clk);
        check("loadm_mux", {63'd0, MUXSelect}, 64'd1);
        check("loadm_wr", {59'd0, wrAddr}, 64'd7);
        @(negedge clk);
        check("loadm_mux_off", {63'd0, MUXSelect}, 64'd0);

        // ALU FS=01100 srcA=0 srcB=1 dest=5 Cin=1, stat low 4 EXEC cycles
        send({3'b010, 5'b01100, 5'd5, 5'd0, 5'd1, 1'b1, 8'd0});
        check("alu_cin", {63'd0, Cin}, 64'd1);
        check("alu_fs", {59'd0, FS}, 64'h0C);
        @(negedge clk);
        check("alu_start", {63'd0, ALUstart}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("alu_wait", {63'd0, ALUstart}, 64'd1);
            check("alu_no_rw", {63'd0, RegWrite}, 64'd0);
        end
        stat = 1'b1; Cout = 1'b1;
        @(negedge clk);
        stat = 1'b0; Cout = 1'b0;
        check("alu_start_off", {63'd0, ALUstart}, 64'd0);
        check("alu_rw", {63'd0, RegWrite}, 64'd1);
        check("alu_wr", {59'd0, wrAddr}, 64'd5);
        check("alu_insel", {63'd0, InSelect}, 64'd1);
        check("alu_carry", {63'd0, carry_flag}, 64'd1);
        @(negedge clk);
        check("alu_ready", {63'd0, instr_ready}, 64'd1);

        // STORE srcA=4 with stat already high on EXEC entry
        stat = 1'b1; Cout = 1'b0;
        send({3'b011, 5'b00011, 5'd9, 5'd4, 5'd6, 1'b0, 8'd0});
        @(negedge clk);
        check("st_fs", {59'd0, FS}, 64'h08);
        check("st_start", {63'd0, ALUstart}, 64'd1);
        @(negedge clk);
        check("st_stale", {63'd0, ALUstart}, 64'd1);
        check("st_no_ram", {63'd0, RAMWrite}, 64'd0);
        @(negedge clk);
        stat = 1'b0;
        check("st_ram", {63'd0, RAMWrite}, 64'd1);
        check("st_ra", {59'd0, rdAddrA}, 64'd4);
        check("st_carry", {63'd0, carry_flag}, 64'd0);
        @(negedge clk);
        check("st_ram_off", {63'd0, RAMWrite}, 64'd0);
        check("st_ready", {63'd0, instr_ready}, 64'd1);

        // Illegal opcode 110, then HALT
        send({3'b110, 29'd0});
        @(negedge clk);
        check("ill_flag", {63'd0, illegal_op}, 64'd1);
        check("ill_ready", {63'd0, instr_ready}, 64'd1);
        send({3'b111, 29'd0});
        @(negedge clk);
        check("halt_flag", {63'd0, halted}, 64'd1);
        check("halt_ready", {63'd0, instr_ready}, 64'd0);
        instr = 32'd0; instr_valid = 1'b1;
        repeat (5) @(negedge clk);
        instr_valid = 1'b0;
        check("halt_stays", {63'd0, halted}, 64'd1);
        check("halt_busy", {63'd0, busy}, 64'd0);

        // Reset leaves HALT and clears sticky flags
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_halted", {63'd0, halted}, 64'd0);
        check("rst2_ill", {63'd0, illegal_op}, 64'd0);
        check("rst2_ready", {63'd0, instr_ready}, 64'd1);

        // Reset during EXEC of an ALU op
        rw_base = rw_cnt;
        send({3'b010, 5'b00001, 5'd2, 5'd3, 5'd4, 1'b0, 8'd0});
        @(negedge clk);
        @(negedge clk);
        check("rexec_start", {63'd0, ALUstart}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rexec_start_off", {63'd0, ALUstart}, 64'd0);
        check("rexec_rw", {63'd0, RegWrite}, 64'd0);
        check("rexec_ready", {63'd0, instr_ready}, 64'd1);
        stat = 1'b1;
        repeat (3) @(negedge clk);
        stat = 1'b0;
        check("rexec_no_pulse", 64'(rw_cnt - rw_base), 64'd0);

`ifdef CTRL_ALU_TIMEOUT_EN
        // Watchdog: stat tied low
        rw_base  = rw_cnt;
        alu_base = alu_cnt;
        send({3'b010, 5'b00010, 5'd6, 5'd1, 5'd2, 1'b0, 8'd0});
        begin
            int k;
            k = 0;
            while (instr_ready !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("to_wait_bound", {63'd0, instr_ready}, 64'd1);
        end
        check("to_flag", {63'd0, alu_timeout}, 64'd1);
        check("to_cycles", 64'(alu_cnt - alu_base), 64'd15);
        check("to_no_rw", 64'(rw_cnt - rw_base), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
